// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/response bundle between a core and the RV32M
//                multiply/divide unit.
//                Request  : start, funct3[2:0], op_a[31:0], op_b[31:0],
//                           rd_in[4:0]
//                Response : busy, done, result[31:0], rd_out[4:0], reg_write
//                master = requester (core), slave = muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, reg_write
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out, reg_write
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//                restoring divide on operand magnitudes, one bit per clock
//                (32 iterations), with sign correction on completion.
//                Divide-by-zero and signed overflow finish without iterating.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                bus.slave  - start/funct3/op_a/op_b/rd_in in,
//                             busy/done/result/rd_out/reg_write out
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] c_MIN_INT  = 32'h8000_0000;
  localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [4:0]  c_LAST_IT  = 5'd31;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_cnt;
  logic [1:0]  r_op;        // funct3[1:0]; funct3[2] is implied by the state
  logic [4:0]  r_rd;
  logic        r_neg_a;
  logic        r_neg_b;
  logic [31:0] r_a;         // |op_a|: multiplicand
  logic [31:0] r_b;         // |op_b|: divisor
  logic [63:0] r_acc;       // product accumulator, multiplier in low half
  logic [31:0] r_quo;       // dividend shifts out as quotient shifts in
  logic [32:0] r_rem;       // partial remainder
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;
  logic        r_busy;
  logic        r_done;

  // ---------------------------------------------------------------- decode
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_last;

  assign w_a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_neg_a    = w_a_signed & bus.op_a[31];
  assign w_neg_b    = w_b_signed & bus.op_b[31];
  assign w_mag_a    = w_neg_a ? (32'd0 - bus.op_a) : bus.op_a;
  assign w_mag_b    = w_neg_b ? (32'd0 - bus.op_b) : bus.op_b;
  assign w_div_zero = bus.funct3[2] & (bus.op_b == 32'd0);
  assign w_div_ovf  = bus.funct3[2] & ~bus.funct3[0] &
                      (bus.op_a == c_MIN_INT) & (bus.op_b == c_ALL_ONES);
  assign w_last     = (r_cnt == c_LAST_IT);

  // ------------------------------------------------------- multiply step
  logic [32:0] w_mul_sum;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;

  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_acc_nxt = {w_mul_sum, r_acc[31:1]};
  assign w_prod    = (r_neg_a ^ r_neg_b) ? (64'd0 - w_acc_nxt) : w_acc_nxt;
  assign w_mul_res = (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  // -------------------------------------------------------- divide step
  // Shift the next dividend bit into the remainder and try subtracting the
  // divisor; bit 33 of the trial is the borrow that says "does not fit".
  logic [33:0] w_div_shift;
  logic [33:0] w_div_trial;
  logic        w_div_fit;
  logic [32:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_div_res;

  assign w_div_shift = {r_rem, r_quo[31]};
  assign w_div_trial = w_div_shift - {2'b00, r_b};
  assign w_div_fit   = ~w_div_trial[33];
  assign w_rem_nxt   = w_div_fit ? w_div_trial[32:0] : w_div_shift[32:0];
  assign w_quo_nxt   = {r_quo[30:0], w_div_fit};
  assign w_quo_fix   = (r_neg_a ^ r_neg_b) ? (32'd0 - w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix   = r_neg_a ? (32'd0 - w_rem_nxt[31:0]) : w_rem_nxt[31:0];
  assign w_div_res   = r_op[1] ? w_rem_fix : w_quo_fix;

  // --------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_div_zero || w_div_ovf) begin
            w_state_nxt = S_DONE;
          end else if (bus.funct3[2]) begin
            w_state_nxt = S_DIV;
          end else begin
            w_state_nxt = S_MUL;
          end
        end
      end
      S_MUL:   if (w_last) w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 5'd0;
      r_op     <= 2'd0;
      r_rd     <= 5'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 64'd0;
      r_quo    <= 32'd0;
      r_rem    <= 33'd0;
      r_result <= 32'd0;
      r_rd_out <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Status flags follow the next state so they come straight from flops.
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.funct3[1:0];
            r_rd    <= bus.rd_in;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_cnt   <= 5'd0;
            r_acc   <= {32'd0, w_mag_b};
            r_quo   <= w_mag_a;
            r_rem   <= 33'd0;
            // Shortcut cases publish their result now; divide-by-zero wins.
            if (w_div_zero) begin
              r_result <= bus.funct3[1] ? bus.op_a : c_ALL_ONES;
              r_rd_out <= bus.rd_in;
            end else if (w_div_ovf) begin
              r_result <= bus.funct3[1] ? 32'd0 : c_MIN_INT;
              r_rd_out <= bus.rd_in;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_result <= w_mul_res;
            r_rd_out <= r_rd;
          end
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_result <= w_div_res;
            r_rd_out <= r_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.reg_write = r_done;
  assign bus.result    = r_result;
  assign bus.rd_out    = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_unit_if bus();

  muldiv_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE and wait (bounded) for done.
  // lat = 1 means done seen in the cycle after the accepting edge; -1 = timeout.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output logic wr, output logic busy1);
    int guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    busy1      = bus.busy;
    bus.start  = 1'b0;
    bus.funct3 = ~f3;
    bus.op_a   = ~a;
    bus.op_b   = b ^ 32'h5A5A_A5A5;
    bus.rd_in  = ~rd;
    lat = 1;
    while (!bus.done && lat <= 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) lat = -1;
    res = bus.result;
    rdo = bus.rd_out;
    wr  = bus.reg_write;
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_write !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: busy=%b done=%b reg_write=%b, required 0 0 0",
               bus.busy, bus.done, bus.reg_write);
    end
    n_checks++;
    if (bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_data: result=%h rd_out=%0d, required 00000000 0", bus.result, bus.rd_out);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, b1;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, rdo, wr, b1);
    n_checks++;
    if (b1 !== 1'b1) begin n_errors++; $display("FAIL mul_busy: busy=%b, required 1", b1); end
    n_checks++;
    if (lat != 33) begin n_errors++; $display("FAIL mul_latency: got %0d, required 33", lat); end
    n_checks++;
    if (res !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mul_result: got %h, required ffffffeb", res); end
    n_checks++;
    if (rdo !== 5'd5 || wr !== 1'b1) begin
      n_errors++; $display("FAIL mul_rd: rd_out=%0d reg_write=%b, required 5 1", rdo, wr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.reg_write !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_pulse: done=%b reg_write=%b busy=%b, required 0 0 0",
               bus.done, bus.reg_write, bus.busy);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [0:5];
    logic [31:0] as  [0:5];
    logic [31:0] bs  [0:5];
    logic [31:0] exs [0:5];
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, b1;
    f3s[0] = 3'b001; as[0] = 32'h8000_0000; bs[0] = 32'h8000_0000; exs[0] = 32'h4000_0000;
    f3s[1] = 3'b011; as[1] = 32'h8000_0000; bs[1] = 32'h8000_0000; exs[1] = 32'h4000_0000;
    f3s[2] = 3'b010; as[2] = 32'hFFFF_FFFF; bs[2] = 32'hFFFF_FFFF; exs[2] = 32'hFFFF_FFFF;
    f3s[3] = 3'b011; as[3] = 32'hFFFF_FFFF; bs[3] = 32'hFFFF_FFFF; exs[3] = 32'hFFFF_FFFE;
    f3s[4] = 3'b000; as[4] = 32'hFFFF_FFFF; bs[4] = 32'hFFFF_FFFF; exs[4] = 32'h0000_0001;
    f3s[5] = 3'b001; as[5] = 32'hFFFF_FFFF; bs[5] = 32'hFFFF_FFFF; exs[5] = 32'h0000_0000;
    for (int i = 0; i < 6; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(i + 10), lat, res, rdo, wr, b1);
      n_checks++;
      if (lat != 33 || res !== exs[i] || rdo !== 5'(i + 10)) begin
        n_errors++;
        $display("FAIL mulh_%0d: lat=%0d result=%h rd_out=%0d, required 33 %h %0d",
                 i, lat, res, rdo, exs[i], i + 10);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [0:7];
    logic [31:0] as  [0:7];
    logic [31:0] bs  [0:7];
    logic [31:0] exs [0:7];
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, b1;
    f3s[0] = 3'b100; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;          exs[0] = 32'hFFFF_FFFD;
    f3s[1] = 3'b110; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;          exs[1] = 32'hFFFF_FFFF;
    f3s[2] = 3'b101; as[2] = 32'd100;       bs[2] = 32'd7;          exs[2] = 32'd14;
    f3s[3] = 3'b111; as[3] = 32'd100;       bs[3] = 32'd7;          exs[3] = 32'd2;
    f3s[4] = 3'b100; as[4] = 32'd7;         bs[4] = 32'hFFFF_FFFE;  exs[4] = 32'hFFFF_FFFD;
    f3s[5] = 3'b110; as[5] = 32'd7;         bs[5] = 32'hFFFF_FFFE;  exs[5] = 32'd1;
    f3s[6] = 3'b101; as[6] = 32'h8000_0000; bs[6] = 32'hFFFF_FFFF;  exs[6] = 32'd0;
    f3s[7] = 3'b111; as[7] = 32'hFFFF_FFFF; bs[7] = 32'd10;         exs[7] = 32'd5;
    for (int i = 0; i < 8; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(i + 1), lat, res, rdo, wr, b1);
      n_checks++;
      if (lat != 33 || res !== exs[i] || rdo !== 5'(i + 1)) begin
        n_errors++;
        $display("FAIL div_%0d: lat=%0d result=%h rd_out=%0d, required 33 %h %0d",
                 i, lat, res, rdo, exs[i], i + 1);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [0:5];
    logic [31:0] as  [0:5];
    logic [31:0] bs  [0:5];
    logic [31:0] exs [0:5];
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, b1;
    f3s[0] = 3'b100; as[0] = 32'd5;         bs[0] = 32'd0;         exs[0] = 32'hFFFF_FFFF;
    f3s[1] = 3'b111; as[1] = 32'h0000_1234; bs[1] = 32'd0;         exs[1] = 32'h0000_1234;
    f3s[2] = 3'b100; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; exs[2] = 32'h8000_0000;
    f3s[3] = 3'b110; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; exs[3] = 32'd0;
    f3s[4] = 3'b110; as[4] = 32'hFFFF_FFF9; bs[4] = 32'd0;         exs[4] = 32'hFFFF_FFF9;
    f3s[5] = 3'b101; as[5] = 32'd0;         bs[5] = 32'd0;         exs[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'(i + 20), lat, res, rdo, wr, b1);
      n_checks++;
      if (lat != 1 || res !== exs[i] || rdo !== 5'(i + 20) || wr !== 1'b1) begin
        n_errors++;
        $display("FAIL special_%0d: lat=%0d result=%h rd_out=%0d reg_write=%b, required 1 %h %0d 1",
                 i, lat, res, rdo, wr, exs[i], i + 20);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL special_pulse: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_ignore_start();
    int ndone; int dlat; logic [31:0] dres;
    ndone = 0; dlat = -1; dres = 32'd0;
    @(negedge clk);
    bus.funct3 = 3'b000; bus.op_a = 32'd6; bus.op_b = 32'd7; bus.rd_in = 5'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin ndone++; dlat = c; dres = bus.result; end
      @(negedge clk);
      if (c == 9) begin
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd100; bus.op_b = 32'd100;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone != 1 || dlat != 33 || dres !== 32'd42) begin
      n_errors++;
      $display("FAIL ignore_start: pulses=%0d at=%0d result=%h, required 1 33 0000002a", ndone, dlat, dres);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic [4:0] rdo; logic wr, b1;
    run_op(3'b000, 32'd3, 32'd4, 5'd4, lat, res, rdo, wr, b1);
    n_checks++;
    if (lat != 33 || res !== 32'd12) begin
      n_errors++; $display("FAIL b2b_first: lat=%0d result=%h, required 33 0000000c", lat, res);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.result !== 32'd12 || bus.rd_out !== 5'd4) begin
      n_errors++; $display("FAIL hold_idle: result=%h rd_out=%0d, required 0000000c 4", bus.result, bus.rd_out);
    end
    @(negedge clk);
    bus.funct3 = 3'b101; bus.op_a = 32'd50; bus.op_b = 32'd5; bus.rd_in = 5'd6; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    n_checks++;
    if (bus.result !== 32'd12 || bus.rd_out !== 5'd4 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_busy: result=%h rd_out=%0d busy=%b, required 0000000c 4 1",
               bus.result, bus.rd_out, bus.busy);
    end
    lat = 20;
    while (!bus.done && lat <= 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat != 33 || bus.result !== 32'd10 || bus.rd_out !== 5'd6) begin
      n_errors++;
      $display("FAIL b2b_second: lat=%0d result=%h rd_out=%0d, required 33 0000000a 6",
               lat, bus.result, bus.rd_out);
    end
  endtask

  task automatic test_reset_mid();
    int ndone; int lat; logic [31:0] res; logic [4:0] rdo; logic wr, b1;
    ndone = 0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.funct3 = 3'b100; bus.op_a = 32'h0000_1000; bus.op_b = 32'd3; bus.rd_in = 5'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_write !== 1'b0 ||
        bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_async: busy=%b done=%b reg_write=%b result=%h rd_out=%0d, required 0 0 0 00000000 0",
               bus.busy, bus.done, bus.reg_write, bus.result, bus.rd_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_errors++; $display("FAIL reset_no_done: pulses=%0d, required 0", ndone); end
    run_op(3'b101, 32'd9, 32'd3, 5'd9, lat, res, rdo, wr, b1);
    n_checks++;
    if (lat != 33 || res !== 32'd3 || rdo !== 5'd9) begin
      n_errors++;
      $display("FAIL reset_recover: lat=%0d result=%h rd_out=%0d, required 33 00000003 9", lat, res, rdo);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.rd_in = 5'd0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  request; operands and funct3 are sampled when start=1 in IDLE.
REQ-005 SHALL provide port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL provide port op_a  input  32  rs1 operand, driven from register-file data1.
REQ-007 SHALL provide port op_b  input  32  rs2 operand, driven from register-file data2.
REQ-008 SHALL provide port rd_in  input  5  destination register index.
REQ-009 SHALL provide port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL provide port done  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL provide port result  output  32  value for register-file rd_data.
REQ-012 SHALL provide port rd_out  output  5  latched rd_in, for register-file rd.
REQ-013 SHALL provide port reg_write  output  1  equal to done; rd_out=0 is still reported, and the register file discards it.

Function
REQ-014 SHALL implement the states IDLE, MUL, DIV and DONE.
REQ-015 In IDLE with start=1 at edge N, SHALL latch funct3, rd_in and operand magnitudes/signs, clear the iteration counter, and go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-016 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats op_a as signed and op_b as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-017 MUL SHALL perform one shift-add iteration per edge on the magnitudes into a 64-bit accumulator, with 32 iterations at edges N+1..N+32, then go to DONE.
REQ-018 DIV SHALL perform one restoring iteration per edge (32-bit quotient, 33-bit partial remainder), with 32 iterations at edges N+1..N+32, then go to DONE.
REQ-019 Sign correction SHALL be applied when entering DONE: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of op_a.
REQ-020 result SHALL be product[31:0] for MUL, product[63:32] for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, and the remainder for REM/REMU.
REQ-021 Divide by zero (op_b=0) SHALL skip iteration, going IDLE->DONE at edge N: quotient 0xFFFFFFFF; remainder = op_a unmodified.
REQ-022 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL skip iteration, going IDLE->DONE at edge N: quotient 0x80000000; remainder 0.
REQ-023 Latency: done=1 in the cycle after edge N+32 for iterated ops, and in the cycle after edge N for REQ-021/022 cases.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE; done, reg_write and busy are registered, glitch-free outputs.
REQ-025 start SHALL be ignored in MUL, DIV and DONE; no queuing; a new request is accepted only in IDLE.
REQ-026 result and rd_out SHALL hold their values after done until the next DONE.
REQ-027 op_a/op_b changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, busy 0, done 0, reg_write 0, result 0x00000000, rd_out 0, regardless of clk.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; the first start after release is accepted normally.

Verification
REQ-030 MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> busy from the next cycle; done/reg_write high exactly 33 cycles after start; result 0xFFFFFFEB; rd_out 5.
REQ-031 MULH/MULHU with 0x80000000 x 0x80000000 -> MULH result 0x40000000; MULHU result 0x40000000; MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-033 DIV x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; done one cycle after start in all four cases.
REQ-034 start pulsed again at cycle 10 of a MUL, with new operands -> ignored; single done at cycle 33 with the original result.
REQ-035 rst_n low at cycle 15 of a DIV -> busy, done and result 0 asynchronously; no done pulse; a subsequent DIVU 9/3 returns 3.
